// File: rtl/multicycle_core_p.sv
// multicycle_core_p
// Parametrised multicycle core: 4 registers, 8-bit instruction encoding,
// external memory behind a request/ready handshake with wait states.
//
// Ports
//   clock      system clock, all state updates on the rising edge
//   reset      asynchronous active-high reset
//   mem_req    memory request, held until accepted
//   mem_we     1 = write, 0 = read; valid while mem_req is high
//   mem_addr   request address (PC on fetch, R[b] on data access)
//   mem_wdata  write data (R[a] latched at decode)
//   mem_rdata  read data, sampled in the cycle mem_ready is high
//   mem_ready  request accepted/completed this cycle
//   halted     core is in the HALT state
//   pc_out     current PC
//   flag_n     negative flag
//   flag_z     zero flag
//   dbg_sel    register select for the debug read port
//   dbg_data   R[dbg_sel], combinational
//
// Handshake: a transfer completes on the rising edge where mem_req and
// mem_ready are both high. While mem_req is high and mem_ready is low the
// core holds mem_addr, mem_we and mem_wdata constant (they come only from
// state, PC and registers latched at decode). mem_ready is ignored whenever
// mem_req is low.
//
// The FSM state is kept in the named signal 'state' for observation.

module multicycle_core_p #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flag_n,
    output logic              flag_z,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] alu_out;
    logic              n_q;
    logic              z_q;
    logic              halted_q;

    // ------------------------------------------------------------------
    // Instruction decode (pure function of IR)
    // ------------------------------------------------------------------
    logic [1:0] ra_idx;
    logic [1:0] rb_idx;
    logic [3:0] op;
    logic is_load, is_store, is_add, is_sub, is_nand, is_ori, is_shift;
    logic is_bz, is_bnz, is_bpz, is_branch, is_halt, is_nop;

    assign ra_idx   = ir[7:6];
    assign rb_idx   = ir[5:4];
    assign op       = ir[3:0];
    assign is_load  = (op == 4'b0000);
    assign is_store = (op == 4'b0010);
    assign is_add   = (op == 4'b0100);
    assign is_sub   = (op == 4'b0110);
    assign is_nand  = (op == 4'b1000);
    assign is_ori   = (op[2:0] == 3'b111);
    assign is_shift = (op[2:0] == 3'b011);
    assign is_bz    = (op == 4'b0101);
    assign is_bnz   = (op == 4'b1001);
    assign is_bpz   = (op == 4'b1101);
    assign is_branch = is_bz | is_bnz | is_bpz;
    assign is_halt  = (op == 4'b0001);
    assign is_nop   = (op == 4'b1010) | (op == 4'b1100) | (op == 4'b1110);

    // ------------------------------------------------------------------
    // ALU and branch resolution
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ori_imm;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] br_offset;
    logic [ADDR_W-1:0] br_target;
    logic              br_taken;

    assign ori_imm = {{(DATA_W-5){1'b0}}, ir[7:3]};

    always_comb begin
        alu_res = '0;
        if (is_add) begin
            alu_res = a_reg + b_reg;
        end else if (is_sub) begin
            alu_res = a_reg - b_reg;
        end else if (is_nand) begin
            alu_res = ~(a_reg & b_reg);
        end else if (is_ori) begin
            // a_reg holds R1 for ORI (selected at decode)
            alu_res = a_reg | ori_imm;
        end else if (is_shift) begin
            alu_res = ir[5] ? (a_reg >> ir[4:3]) : (a_reg << ir[4:3]);
        end
    end

    // PC has already been incremented at decode, so it equals the
    // branch address + 1 by the time EXEC evaluates the target.
    assign br_offset = {{(ADDR_W-4){ir[7]}}, ir[7:4]};
    assign br_target = pc + br_offset;
    assign br_taken  = (is_bz & z_q) | (is_bnz & ~z_q) | (is_bpz & ~n_q);

    // ------------------------------------------------------------------
    // Memory interface
    // ------------------------------------------------------------------
    // Gating with reset makes the request drop the instant reset asserts,
    // while still presenting the first fetch right after release.
    assign mem_req   = ~reset & ((state == S_FETCH) | (state == S_MEM));
    assign mem_we    = (state == S_MEM) & is_store;
    assign mem_addr  = (state == S_MEM) ? b_reg[ADDR_W-1:0] : pc;
    assign mem_wdata = a_reg;

    assign halted   = halted_q;
    assign pc_out   = pc;
    assign flag_n   = n_q;
    assign flag_z   = z_q;
    assign dbg_data = regs[dbg_sel];

    // ------------------------------------------------------------------
    // Control FSM and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= PC_RESET;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            mdr      <= '0;
            alu_out  <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[7:0];
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    pc    <= pc + PC_ONE;
                    a_reg <= is_ori ? regs[1] : regs[ra_idx];
                    b_reg <= regs[rb_idx];
                    if (is_halt) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else if (is_nop) begin
                        state <= S_FETCH;
                    end else if (is_load | is_store) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (is_branch) begin
                        if (br_taken) begin
                            pc <= br_target;
                        end
                        state <= S_FETCH;
                    end else begin
                        alu_out <= alu_res;
                        n_q     <= alu_res[DATA_W-1];
                        z_q     <= (alu_res == '0);
                        state   <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (is_store) begin
                            state <= S_FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    if (is_load) begin
                        regs[ra_idx] <= mdr;
                    end else if (is_ori) begin
                        regs[1] <= alu_out;
                    end else begin
                        regs[ra_idx] <= alu_out;
                    end
                    state <= S_FETCH;
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core_p.sv
// Directed testbench for multicycle_core_p. An 8-bit core runs a series of
// small programs against a memory model with programmable wait states; a
// 16-bit core runs the first program alongside it to compare control timing.

module tb_multicycle_core_p;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset;
    logic reset16;

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        mem_req8, mem_we8, mem_ready8, halted8, flag_n8, flag_z8;
    logic [7:0]  mem_addr8, mem_wdata8, mem_rdata8, pc8, dbg8;
    logic [1:0]  dbg_sel8;

    logic        mem_req16, mem_we16, mem_ready16, halted16, flag_n16, flag_z16;
    logic [7:0]  mem_addr16, pc16;
    logic [15:0] mem_wdata16, mem_rdata16, dbg16;
    logic [1:0]  dbg_sel16;

    multicycle_core_p #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req8),
        .mem_we    (mem_we8),
        .mem_addr  (mem_addr8),
        .mem_wdata (mem_wdata8),
        .mem_rdata (mem_rdata8),
        .mem_ready (mem_ready8),
        .halted    (halted8),
        .pc_out    (pc8),
        .flag_n    (flag_n8),
        .flag_z    (flag_z8),
        .dbg_sel   (dbg_sel8),
        .dbg_data  (dbg8)
    );

    multicycle_core_p #(.DATA_W(16), .ADDR_W(8), .RESET_PC(0)) dut16 (
        .clock     (clock),
        .reset     (reset16),
        .mem_req   (mem_req16),
        .mem_we    (mem_we16),
        .mem_addr  (mem_addr16),
        .mem_wdata (mem_wdata16),
        .mem_rdata (mem_rdata16),
        .mem_ready (mem_ready16),
        .halted    (halted16),
        .pc_out    (pc16),
        .flag_n    (flag_n16),
        .flag_z    (flag_z16),
        .dbg_sel   (dbg_sel16),
        .dbg_data  (dbg16)
    );

    // ------------------------------------------------------------------
    // Memory model: one byte array, written only by the stimulus block.
    // Reads/writes by the 8-bit core wait read_wait/store_wait cycles.
    // The 16-bit core sees 0xA5 in the upper byte of every read.
    // ------------------------------------------------------------------
    logic [7:0] mem [256];
    int read_wait;
    int store_wait;
    int age8;
    int wr_count;
    int rd_count;
    logic [7:0] wr_addr, wr_data, rd_addr;

    always_comb begin
        mem_ready8 = mem_req8 && (age8 >= (mem_we8 ? store_wait : read_wait));
        mem_rdata8 = mem[mem_addr8];
        mem_ready16 = mem_req16;
        mem_rdata16 = {8'hA5, mem[mem_addr16]};
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            age8 <= 0;
        end else if (!mem_req8 || mem_ready8) begin
            age8 <= 0;
        end else begin
            age8 <= age8 + 1;
        end
    end

    always @(posedge clock) begin
        if (mem_req8 && mem_ready8) begin
            if (mem_we8) begin
                wr_count <= wr_count + 1;
                wr_addr  <= mem_addr8;
                wr_data  <= mem_wdata8;
            end else begin
                rd_count <= rd_count + 1;
                rd_addr  <= mem_addr8;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total = n_total + 1;
        assert (obs === want) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reg(input int idx, input logic [7:0] want, input string tag);
        dbg_sel8 = idx[1:0];
        #1;
        check(tag, {24'h0, dbg8}, {24'h0, want});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Holds reset for two edges and releases it on a falling edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        read_wait = 0;
        store_wait = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n = 0;
        while (!halted8 && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {31'h0, halted8}, 32'h1);
    endtask

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int wr0;
        int rd0;
        logic [15:0] exp_wr;

        reset = 1'b1;
        reset16 = 1'b1;
        dbg_sel8 = 2'd0;
        dbg_sel16 = 2'd0;
        read_wait = 0;
        store_wait = 0;
        wr_count = 0;
        rd_count = 0;

        // ---- 1: LOAD / ADD / HALT on both widths ----
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h14; mem[2] = 8'h01;
        step(2);
        check("rst_req", {31'h0, mem_req8}, 32'h0);
        check("rst_halted", {31'h0, halted8}, 32'h0);
        check("rst_pc", {24'h0, pc8}, 32'h0);
        check("rst_flags", {30'h0, flag_n8, flag_z8}, 32'h0);
        check("rst_req16", {31'h0, mem_req16}, 32'h0);
        for (int r = 0; r < 4; r++) check_reg(r, 8'h00, "rst_reg");
        @(negedge clock);
        reset = 1'b0;
        reset16 = 1'b0;
        #1;
        check("first_fetch_req", {31'h0, mem_req8}, 32'h1);
        check("first_fetch_addr", {24'h0, mem_addr8}, 32'h0);
        step(9);
        check("s1_not_halted_9", {31'h0, halted8}, 32'h0);
        check("s1_not_halted16_9", {31'h0, halted16}, 32'h0);
        step(1);
        check("s1_halted_10", {31'h0, halted8}, 32'h1);
        check("s1_halted16_10", {31'h0, halted16}, 32'h1);
        check("s1_pc", {24'h0, pc8}, 32'h3);
        check("s1_pc16", {24'h0, pc16}, 32'h3);
        check("s1_z", {31'h0, flag_z8}, 32'h1);
        check("s1_n", {31'h0, flag_n8}, 32'h0);
        check("s1_req_halt", {31'h0, mem_req8}, 32'h0);
        check_reg(0, 8'h00, "s1_r0");
        dbg_sel16 = 2'd0;
        #1;
        check("s1_r0_16", {16'h0, dbg16}, 32'hA500);
        check("s1_n16", {31'h0, flag_n16}, 32'h1);
        check("s1_z16", {31'h0, flag_z16}, 32'h0);
        check("s1_req16_halt", {31'h0, mem_req16}, 32'h0);
        reset16 = 1'b1;
        step(3);
        check("s1_hold_pc", {24'h0, pc8}, 32'h3);
        check("s1_hold_halted", {31'h0, halted8}, 32'h1);

        // ---- 2: ORI / SUB / SHIFT / ADD overflow / NAND ----
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'h56; mem[2] = 8'hFF; mem[3] = 8'h53;
        mem[4] = 8'h1F; mem[5] = 8'h14; mem[6] = 8'h56; mem[7] = 8'h0F;
        mem[8] = 8'h14; mem[9] = 8'h08; mem[10] = 8'h01;
        do_reset();
        step(4);
        check_reg(1, 8'h1F, "ori_r1");
        check("ori_flags", {30'h0, flag_n8, flag_z8}, 32'h0);
        step(4);
        check_reg(1, 8'h00, "sub_r1");
        check("sub_z", {31'h0, flag_z8}, 32'h1);
        check("sub_n", {31'h0, flag_n8}, 32'h0);
        step(28);
        check_reg(0, 8'h80, "add_ovf_r0");
        check("add_ovf_n", {31'h0, flag_n8}, 32'h1);
        check("add_ovf_z", {31'h0, flag_z8}, 32'h0);
        wait_halt(20, "s2_halt");
        check_reg(0, 8'h7F, "nand_r0");
        check("nand_n", {31'h0, flag_n8}, 32'h0);
        check("nand_z", {31'h0, flag_z8}, 32'h0);
        check("s2_pc", {24'h0, pc8}, 32'h0B);

        // ---- 3: SHIFT left/right ----
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'hD0; mem[2] = 8'hB4; mem[3] = 8'h56;
        mem[4] = 8'h0F; mem[5] = 8'h94; mem[6] = 8'h8B; mem[7] = 8'hFB;
        mem[8] = 8'h01; mem[8'h1F] = 8'h80;
        do_reset();
        step(24);
        check_reg(2, 8'h81, "shl_src");
        check("shl_src_n", {31'h0, flag_n8}, 32'h1);
        step(4);
        check_reg(2, 8'h02, "shl_res");
        check("shl_n", {31'h0, flag_n8}, 32'h0);
        check("shl_z", {31'h0, flag_z8}, 32'h0);
        step(4);
        check_reg(3, 8'h10, "shr_res");
        wait_halt(10, "s3_halt");
        check("s3_pc", {24'h0, pc8}, 32'h09);

        // ---- 4: BZ not taken, then taken loop at address 0 ----
        clear_mem();
        mem[0] = 8'hF5; mem[1] = 8'h06; mem[2] = 8'hD5;
        do_reset();
        step(3);
        check("bz_nt_pc", {24'h0, pc8}, 32'h1);
        check("bz_nt_addr", {24'h0, mem_addr8}, 32'h1);
        step(4);
        check("bz_sub_z", {31'h0, flag_z8}, 32'h1);
        step(3);
        check("bz_back_pc", {24'h0, pc8}, 32'h0);
        step(2);
        check("bz_loop_inc", {24'h0, pc8}, 32'h1);
        step(1);
        check("bz_loop_pc", {24'h0, pc8}, 32'h0);
        check("bz_loop_addr", {24'h0, mem_addr8}, 32'h0);
        check("bz_loop_req", {31'h0, mem_req8}, 32'h1);

        // ---- 5: BNZ to 0xFF, BPZ across the wrap ----
        clear_mem();
        mem[0] = 8'hE9; mem[8'hFF] = 8'h1D; mem[1] = 8'h01;
        do_reset();
        step(3);
        check("bnz_pc", {24'h0, pc8}, 32'hFF);
        check("bnz_addr", {24'h0, mem_addr8}, 32'hFF);
        step(2);
        check("pc_wrap_inc", {24'h0, pc8}, 32'h00);
        step(1);
        check("bpz_wrap_pc", {24'h0, pc8}, 32'h01);
        wait_halt(10, "s5_halt");
        check("s5_pc", {24'h0, pc8}, 32'h02);

        // ---- 6: NOPs (upper nibble varies) take 2 cycles ----
        clear_mem();
        mem[0] = 8'hFA; mem[1] = 8'h5C; mem[2] = 8'hAE; mem[3] = 8'h01;
        do_reset();
        step(2);
        check("nop1_pc", {24'h0, pc8}, 32'h1);
        check("nop1_req", {31'h0, mem_req8}, 32'h1);
        step(2);
        check("nop2_pc", {24'h0, pc8}, 32'h2);
        step(2);
        check("nop3_pc", {24'h0, pc8}, 32'h3);
        step(2);
        check("nop_halt", {31'h0, halted8}, 32'h1);
        check("nop_flags", {30'h0, flag_n8, flag_z8}, 32'h0);

        // ---- 7: wait states on fetch and store ----
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'h42; mem[2] = 8'h01;
        do_reset();
        step(4);
        check_reg(1, 8'h1F, "ws_setup_r1");
        read_wait = 3;
        store_wait = 2;
        exp_q.push_back({8'h00, 8'h1F});
        wr0 = wr_count;
        for (int c = 0; c < 4; c++) begin
            check("ws_fetch_req", {31'h0, mem_req8}, 32'h1);
            check("ws_fetch_addr", {24'h0, mem_addr8}, 32'h1);
            check("ws_fetch_we", {31'h0, mem_we8}, 32'h0);
            step(1);
        end
        check("ws_decode_req", {31'h0, mem_req8}, 32'h0);
        step(1);
        for (int c = 0; c < 3; c++) begin
            check("ws_store_req", {31'h0, mem_req8}, 32'h1);
            check("ws_store_we", {31'h0, mem_we8}, 32'h1);
            check("ws_store_addr", {24'h0, mem_addr8}, 32'h0);
            check("ws_store_wdata", {24'h0, mem_wdata8}, 32'h1F);
            step(1);
        end
        check("ws_next_fetch", {24'h0, mem_addr8}, 32'h2);
        check("ws_next_we", {31'h0, mem_we8}, 32'h0);
        check("ws_wr_once", wr_count, wr0 + 1);
        exp_wr = exp_q.pop_front();
        check("ws_wr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr});
        wait_halt(20, "ws_halt");
        check("ws_wr_still_once", wr_count, wr0 + 1);

        // ---- 8: reset during a LOAD memory wait ----
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'h90; mem[8'h1F] = 8'h5A;
        do_reset();
        step(5);
        read_wait = 5;
        step(1);
        check("rl_mem_req", {31'h0, mem_req8}, 32'h1);
        check("rl_mem_addr", {24'h0, mem_addr8}, 32'h1F);
        step(1);
        check("rl_still_wait", {31'h0, mem_req8}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("rl_async_drop", {31'h0, mem_req8}, 32'h0);
        check("rl_pc", {24'h0, pc8}, 32'h0);
        for (int r = 0; r < 4; r++) check_reg(r, 8'h00, "rl_reg");
        read_wait = 0;
        rd0 = rd_count;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rl_rel_req", {31'h0, mem_req8}, 32'h1);
        check("rl_rel_addr", {24'h0, mem_addr8}, 32'h0);
        step(1);
        check("rl_first_rd", rd_count, rd0 + 1);
        check("rl_first_rd_addr", {24'h0, rd_addr}, 32'h0);
        check("rl_decode_req", {31'h0, mem_req8}, 32'h0);
        step(1);
        check("rl_pc_after", {24'h0, pc8}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_core_p.md
Name: multicycle_core_p

Overview:
Parametrised next-generation multicycle processor core for the DE2 lab platform. It keeps the 4-register, 8-bit-encoded ISA and adds configurable datapath and address width. Memory moves outside the core behind a req/ready handshake with wait states, and the ISA gains HALT and NOP. The board top-level instantiates it with external memory, HEX and LED debug wiring.

Parameters:
DATA_W, 8, register/ALU/memory word width; must be ≥ 8 and ≥ ADDR_W
ADDR_W, 8, PC and memory address width; a memory address is R[b][ADDR_W-1:0]
RESET_PC, 0, PC value after reset

Ports:
clock  in  1  single system clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
mem_req  out  1  memory request, held until accepted
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data (R[a])
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready=1
mem_ready  in  1  request accepted/completed this cycle
halted  out  1  core is in HALT state
pc_out  out  ADDR_W  current PC
flag_n, flag_z  out  1 each  N and Z flags
dbg_sel  in  2  register select for the debug read port
dbg_data  out  DATA_W  R[dbg_sel], combinational

Behaviour:
- Reset (async): PC=RESET_PC; R0..R3, IR, MDR, ALUOut, N and Z = 0; state=FETCH; mem_req/mem_we=0, halted=0.
- Instruction = fetched word [7:0]; upper bits are ignored. a=IR[7:6], b=IR[5:4], op=IR[3:0].
- ISA:
  - 0000 LOAD: R[a] ← mem[R[b]]
  - 0010 STORE: mem[R[b]] ← R[a]
  - 0100 ADD: R[a] ← R[a] + R[b]
  - 0110 SUB: R[a] ← R[a] − R[b]
  - 1000 NAND: R[a] ← ~(R[a] & R[b])
  - x111 ORI: R1 ← R1 | zext(IR[7:3])
  - x011 SHIFT: R[a] ← R[a] shifted logically by IR[4:3]; IR[5]=0 shifts left, 1 shifts right
  - 0101 BZ (taken if Z=1), 1001 BNZ (taken if Z=0), 1101 BPZ (taken if N=0)
  - 0001 HALT
  - 1010, 1100, 1110: NOP
- Arithmetic is modulo 2^DATA_W. ADD, SUB, NAND, ORI and SHIFT update flags: Z = (result==0), N = result[DATA_W-1]. No other instruction touches the flags.
- Branch target = (branch address + 1) + sext(IR[7:4]), modulo 2^ADDR_W. PC wraps on increment.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC; wait while mem_ready=0. On ready, IR ← rdata[7:0] → DECODE.
  - DECODE: PC ← PC+1; latch R[a] and R[b] (R1 for ORI). HALT → HALT; NOP → FETCH; LOAD/STORE → MEM; others → EXEC.
  - EXEC, ALU ops: ALUOut and flags ← result → WB.
  - EXEC, branch: if taken, PC ← target → FETCH.
  - MEM: mem_req=1, mem_addr=R[b], mem_we=STORE, mem_wdata=R[a]; wait for mem_ready. LOAD latches MDR → WB; STORE → FETCH.
  - WB: destination ← ALUOut or MDR → FETCH.
  - HALT: hold all state, halted=1, mem_req=0. Only reset exits.
- Cycle counts with zero-wait memory (ready in the first request cycle): ALU ops 4, LOAD 4, STORE 3, branch 3, NOP 2. Each wait cycle adds 1.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ready=0. A transfer completes at the edge where req&ready=1. mem_req is 0 in every non-FETCH/MEM state. mem_ready while req=0 is ignored.
- Reset asserted mid-request drops mem_req immediately. The first fetch after release is at RESET_PC.
- Register writes never occur in the same cycle as a flag-only event; there is no bypass requirement.

Test Plan:
- DATA_W=8, zero-wait: mem[0]=0x00 (LOAD R0←mem[R0]=0x00), mem[1]=0x14 (ADD R0←R0+R1), mem[2]=0x01 (HALT) → R0=0x00; halted=1 after 2+4+4+2 cycles with PC=3; Z=1.
- ORI then SUB: program sets R1=0x1F via 0xFF; SUB R1−R1 → R1=0, Z=1, N=0. ADD of 0x7F+0x01 → 0x80, N=1, Z=0.
- Branch wrap: BZ with IR[7:4]=0xF at address 0 and Z=1 → next fetch at address 0 (loop). Same instruction with Z=0 → next fetch at 1. A branch at 0xFF with offset +1 → 0x01.
- Wait states: mem_ready held low 3 cycles on FETCH and 2 cycles on STORE → mem_addr/mem_wdata constant throughout; STORE completes in 3+5 cycles; memory written exactly once.
- SHIFT: R2=0x81; SHIFT left 1 → 0x02, N=0. Shift right 3 of 0x80 → 0x10.
- Reset during a LOAD MEM wait → mem_req falls asynchronously; R0..R3=0, PC=0. After release, FETCH at 0 on the first edge. DATA_W=16 rerun of the first scenario gives the same control timing.
